hazard_scoreboard: RTL

//  Parametrised hazard/forwarding controller for the in-order integer pipeline.

---
 rtl/hazard_scoreboard_if.sv | 34 +++
 rtl/hazard_scoreboard.sv | 105 ++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard bundle: decode-side instruction fields in, stall/forwarding/tracking state out.
// Latency: none; this is a wiring bundle only.
// Backpressure: stall is returned to the decode (master) side, which holds its inputs while it is high.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int NSRC   = 2,
    parameter int CNT_W  = 16
);
    localparam int SELW = $clog2(DEPTH);

    logic                    id_valid;
    logic [NSRC*REG_AW-1:0]  id_rs;
    logic [NSRC-1:0]         id_rs_used;
    logic [REG_AW-1:0]       id_rd;
    logic                    id_we;
    logic                    id_is_load;
    logic                    flush;
    logic                    stall;
    logic [NSRC*SELW-1:0]    fwd_sel;
    logic [DEPTH-1:0]        stage_valid;
    logic [DEPTH*REG_AW-1:0] stage_rd;
    logic [CNT_W-1:0]        stall_cycles;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_we, id_is_load, flush,
        input  stall, fwd_sel, stage_valid, stage_rd, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_we, id_is_load, flush,
        output stall, fwd_sel, stage_valid, stage_rd, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight writes EX..WB and checks decode sources (macro FORWARDING_EN enables forwarding).
// Latency: stall and fwd_sel are combinational from decode inputs; tracking chain advances one stage per clock.
// Backpressure: raises stall to hold IF/decode and injects a bubble into stage 0; the chain itself never stalls.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_scoreboard_if.slave   sb
);
    localparam int SELW = $clog2(DEPTH);

    logic [DEPTH-1:0]              r_vld;
    logic [DEPTH-1:0][REG_AW-1:0]  r_rd;
    logic [CNT_W-1:0]              r_cnt;

    logic [NSRC-1:0]               w_haz;
    logic [NSRC-1:0]               w_found;
    logic [NSRC-1:0][SELW-1:0]     w_sel;
    logic                          w_stall;
    logic                          w_push;

`ifdef FORWARDING_EN
    logic [DEPTH-1:0]              r_ld;
    logic                          w_unused_ld;

    // The WB stage load flag is never consulted: WB is covered by the write-first register file.
    assign w_unused_ld = r_ld[DEPTH-1];
`else
    logic                          w_unused_cfg;

    // Load type only matters when forwarding distinguishes load results.
    assign w_unused_cfg = sb.id_is_load ^ (LOAD_LAT != 0);
`endif

    // Per-source match against stages 0..DEPTH-2; the youngest (first found) match decides.
    always_comb begin
        w_haz   = '0;
        w_found = '0;
        w_sel   = '0;
        for (int s = 0; s < NSRC; s++) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                if (!w_found[s] && sb.id_rs_used[s] &&
                    (sb.id_rs[s*REG_AW +: REG_AW] != '0) &&
                    r_vld[k] && (r_rd[k] == sb.id_rs[s*REG_AW +: REG_AW])) begin
                    w_found[s] = 1'b1;
`ifdef FORWARDING_EN
                    if (r_ld[k] && (k < LOAD_LAT)) begin
                        w_haz[s] = 1'b1;
                    end else begin
                        w_sel[s] = SELW'(k + 1);
                    end
`else
                    w_haz[s] = 1'b1;
`endif
                end
            end
        end
    end

    // Flush wins over stall; a stalled or flushed slot enters the chain as a bubble.
    assign w_stall = sb.id_valid && !sb.flush && (|w_haz);
    assign w_push  = sb.id_valid && sb.id_we && (sb.id_rd != '0) && !w_stall && !sb.flush;

    // Tracking chain: shifts every clock, stage 0 takes the issuing write or a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
            r_rd  <= '0;
        end else begin
            r_vld <= {r_vld[DEPTH-2:0], w_push};
            r_rd  <= {r_rd[DEPTH-2:0], (w_push ? sb.id_rd : {REG_AW{1'b0}})};
        end
    end

`ifdef FORWARDING_EN
    // Load flag travels alongside the destination so early-stage load results are held off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ld <= '0;
        end else begin
            r_ld <= {r_ld[DEPTH-2:0], (w_push && sb.id_is_load)};
        end
    end
`endif

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign sb.stall        = w_stall;
    assign sb.fwd_sel      = w_sel;
    assign sb.stage_valid  = r_vld;
    assign sb.stage_rd     = r_rd;
    assign sb.stall_cycles = r_cnt;
endmodule
